// File: rtl/road_scheduler.sv
// Four-way junction scheduler: round-robin green with duration scaled from each road's sensor average.
// Optional build macro ROAD_SCHED_SKIP_EMPTY_EN skips roads whose average is zero.
//
// state  | meaning
// ALLRED | clearance, every lamp red; on exit the next road is chosen and its green time latched
// GREEN  | cur_road green for the latched time
// YELLOW | cur_road yellow for YELLOW_TIME
module road_scheduler #(
  parameter int unsigned MIN_GREEN   = 5,
  parameter int unsigned MAX_GREEN   = 40,
  parameter int unsigned YELLOW_TIME = 3,
  parameter int unsigned ALLRED_TIME = 2,
  parameter int unsigned GREEN_SHIFT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [7:0] avg_n,
  input  logic [7:0] avg_e,
  input  logic [7:0] avg_s,
  input  logic [7:0] avg_w,
  output logic [1:0] cur_road,
  output logic [1:0] next_road,
  output logic [3:0] green,
  output logic [3:0] yellow,
  output logic [3:0] red
);

  localparam logic [7:0] MIN_G = 8'(MIN_GREEN);
  localparam logic [7:0] MAX_G = 8'(MAX_GREEN);
  localparam logic [7:0] YEL_T = 8'(YELLOW_TIME);
  localparam logic [7:0] ARD_T = 8'(ALLRED_TIME);

  typedef enum logic [1:0] {ALLRED, GREEN, YELLOW} state_t;

  state_t     state;
  logic [7:0] tmr;
  logic [7:0] avg [4];
  logic [1:0] sel;
  logic [7:0] raw_g;
  logic [7:0] green_time;
  logic [3:0] sel_oh;
  logic [3:0] cur_oh;

  assign avg[0] = avg_n;
  assign avg[1] = avg_e;
  assign avg[2] = avg_s;
  assign avg[3] = avg_w;

  always_comb begin
    sel = cur_road + 2'd1;
`ifdef ROAD_SCHED_SKIP_EMPTY_EN
    // First non-empty road in rotation order; all empty falls back to plain rotation.
    for (int k = 4; k >= 1; k--) begin
      if (avg[cur_road + 2'(k)] != 8'd0)
        sel = cur_road + 2'(k);
    end
`endif
    raw_g = avg[sel] >> GREEN_SHIFT;
    if (raw_g < MIN_G)
      green_time = MIN_G;
    else if (raw_g > MAX_G)
      green_time = MAX_G;
    else
      green_time = raw_g;
    sel_oh = 4'b0001 << sel;
    cur_oh = 4'b0001 << cur_road;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ALLRED;
      tmr       <= ARD_T;
      cur_road  <= 2'd3;
      next_road <= 2'd0;
      green     <= 4'b0000;
      yellow    <= 4'b0000;
      red       <= 4'b1111;
    end else if (tick) begin
      if (tmr == 8'd1) begin
        case (state)
          ALLRED: begin
            state     <= GREEN;
            tmr       <= green_time;
            cur_road  <= sel;
            next_road <= sel + 2'd1;
            green     <= sel_oh;
            yellow    <= 4'b0000;
            red       <= ~sel_oh;
          end
          GREEN: begin
            state  <= YELLOW;
            tmr    <= YEL_T;
            green  <= 4'b0000;
            yellow <= cur_oh;
            red    <= ~cur_oh;
          end
          YELLOW: begin
            state  <= ALLRED;
            tmr    <= ARD_T;
            green  <= 4'b0000;
            yellow <= 4'b0000;
            red    <= 4'b1111;
          end
          default: begin
            state  <= ALLRED;
            tmr    <= ARD_T;
            green  <= 4'b0000;
            yellow <= 4'b0000;
            red    <= 4'b1111;
          end
        endcase
      end else begin
        tmr <= tmr - 8'd1;
      end
    end
  end

endmodule
